// File: rtl/bcd2bin_arb.sv
// Two-requester round-robin front end for a shared BCD-to-binary core.
// Captures one operand per transaction, waits for a core_done rising edge or a timeout, returns the result.
module bcd2bin_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [19:0] a0,
  input  logic [19:0] a1,
  output logic        ack0,
  output logic        ack1,
  output logic        valid0,
  output logic        valid1,
  output logic [16:0] res,
  output logic        err,
  output logic        busy,
  output logic        core_init,
  output logic [19:0] core_A,
  input  logic [16:0] core_result,
  input  logic        core_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  valid_q, valid_d;
  logic [16:0] res_q, res_d;
  logic        err_q, err_d;
  logic        init_q, init_d;
  logic [19:0] core_a_q, core_a_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q;

  logic win, done_rise;

  // On a tie the requester that did not win last time gets the grant.
  assign win       = (req0 && req1) ? ~last_q : req1;
  assign done_rise = core_done && !done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      ack_q    <= '0;
      valid_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
      core_a_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      err_q    <= err_d;
      init_q   <= init_d;
      core_a_q <= core_a_d;
      cnt_q    <= cnt_d;
      done_q   <= core_done;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    ack_d    = '0;
    valid_d  = '0;
    res_d    = res_q;
    err_d    = err_q;
    init_d   = 1'b0;
    core_a_d = core_a_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = win;
          last_d       = win;
          core_a_d     = win ? a1 : a0;
          ack_d[win]   = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        init_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion edge wins over a timeout landing on the same cycle.
        if (done_rise) begin
          res_d            = core_result;
          err_d            = 1'b0;
          valid_d[grant_q] = 1'b1;
          state_d          = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          res_d            = '0;
          err_d            = 1'b1;
          valid_d[grant_q] = 1'b1;
          state_d          = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign valid0    = valid_q[0];
  assign valid1    = valid_q[1];
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign core_init = init_q;
  assign core_A    = core_a_q;

endmodule

// File: tb/tb_bcd2bin_arb.sv
// Directed plus randomized checks of bcd2bin_arb against a transaction-level model;
// the bench also plays the shared core, converting core_A digit by digit.
module tb_bcd2bin_arb;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [19:0] a0, a1;
  logic        ack0, ack1, valid0, valid1;
  logic [16:0] res;
  logic        err, busy, core_init;
  logic [19:0] core_A;
  logic [16:0] core_result;
  logic        core_done;

  int total = 0;
  int bad   = 0;
  bit exp_last;

  always #5 clk = ~clk;

  bcd2bin_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .ack0(ack0), .ack1(ack1), .valid0(valid0), .valid1(valid1),
    .res(res), .err(err), .busy(busy), .core_init(core_init),
    .core_A(core_A), .core_result(core_result), .core_done(core_done)
  );

  function automatic int bcd2int(input logic [19:0] b);
    int v = 0;
    for (int i = 4; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Core level seen before WAIT edge e (e = -1 is the level on WAIT entry).
  function automatic bit done_at(input bit stale, input int j, input int e);
    if (e < 0) return stale;
    if (stale) return (e == 0) || (j > 0 && e >= j);
    return (j >= 0) && (e >= j);
  endfunction

  always_comb core_result = 17'(bcd2int(core_A));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with req0/req1/a0/a1 already set; returns at a negedge in IDLE.
  // The winner drops its request after ack; the loser keeps requesting.
  task automatic txn(input bit stale, input int j);
    bit          w, timeout;
    int          fin;
    logic [19:0] op;
    logic [16:0] exp_res;
    w        = (req0 && req1) ? ~exp_last : req1;
    exp_last = w;
    op       = w ? a1 : a0;
    core_done = stale;
    @(posedge clk); @(negedge clk);
    chk("ack0", 32'(ack0), 32'(!w));
    chk("ack1", 32'(ack1), 32'(w));
    chk("busy_start", 32'(busy), 32'd1);
    chk("init_early", 32'(core_init), 32'd0);
    chk("core_A", 32'(core_A), 32'(op));
    if (w) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ack_pulse", 32'({ack1, ack0}), 32'd0);
    chk("init", 32'(core_init), 32'd1);
    fin = TO - 1;
    timeout = 1'b1;
    for (int e = 0; e < TO; e++) begin
      if (timeout && done_at(stale, j, e) && !done_at(stale, j, e - 1)) begin
        fin = e;
        timeout = 1'b0;
      end
    end
    for (int e = 0; e <= fin; e++) begin
      core_done = done_at(stale, j, e);
      @(posedge clk); @(negedge clk);
      if (e == 0) chk("init_pulse", 32'(core_init), 32'd0);
      if (e < fin) chk("valid_early", 32'({valid1, valid0}), 32'd0);
    end
    exp_res = timeout ? 17'd0 : 17'(bcd2int(op));
    chk("valid0", 32'(valid0), 32'(!w));
    chk("valid1", 32'(valid1), 32'(w));
    chk("err", 32'(err), 32'(timeout));
    chk("res", 32'(res), 32'(exp_res));
    chk("busy_resp", 32'(busy), 32'd1);
    chk("core_A_hold", 32'(core_A), 32'(op));
    core_done = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle", 32'(busy), 32'd0);
    chk("valid_pulse", 32'({valid1, valid0}), 32'd0);
    chk("res_hold", 32'(res), 32'(exp_res));
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0; core_done = 1'b0;
    exp_last = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({ack1, ack0, valid1, valid0, err, core_init}), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_core_A", 32'(core_A), 32'd0);
    rst = 1'b1;

    // Tie from reset: requester 0 first, then the still-waiting requester 1.
    req0 = 1'b1; req1 = 1'b1; a0 = rand_bcd(); a1 = 20'h00099;
    txn(0, 2);
    txn(0, 1);
    // Two further ties, each followed by serving the held loser.
    req0 = 1'b1; req1 = 1'b1; a0 = rand_bcd(); a1 = rand_bcd();
    txn(0, 0);
    txn(0, 4);
    req0 = 1'b1; req1 = 1'b1; a0 = rand_bcd(); a1 = rand_bcd();
    txn(0, 2);
    txn(0, 5);

    req0 = 1'b1; a0 = 20'h12345;
    txn(0, 3);
    req0 = 1'b1; a0 = rand_bcd();
    txn(0, -1);        // core never finishes
    req1 = 1'b1; a1 = rand_bcd();
    txn(0, TO - 1);    // completion on the last allowed cycle
    req0 = 1'b1; a0 = rand_bcd();
    txn(0, TO);        // completion one cycle too late
    req1 = 1'b1; a1 = rand_bcd();
    txn(1, 3);         // stale done level on WAIT entry

    // Reset while waiting on the core.
    req0 = 1'b1; a0 = rand_bcd();
    @(posedge clk); @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", 32'({ack1, ack0, valid1, valid0, err, core_init}), 32'd0);
    chk("midrst_res", 32'(res), 32'd0);
    chk("midrst_core_A", 32'(core_A), 32'd0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    rst = 1'b1;
    exp_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_quiet", 32'({busy, valid1, valid0, core_init}), 32'd0);
    end
    req1 = 1'b1; a1 = rand_bcd();
    txn(0, 2);

    for (int n = 0; n < 30; n++) begin
      bit st;
      int j;
      if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; a0 = rand_bcd(); end
      if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; a1 = rand_bcd(); end
      if (!req0 && !req1) begin req0 = 1'b1; a0 = rand_bcd(); end
      st = ($urandom_range(0, 3) == 0);
      j  = int'($urandom_range(0, 9)) - 1;
      txn(st, j);
    end
    for (int n = 0; n < 2; n++) begin
      if (req0 || req1) txn(0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
